axi_full_burst_writer: RTL and testbench
========================================

# axi_full_burst_writer

Downstream neighbour of the video-to-FIFO packer in the video-DDR write path. Accepts one line-write request per video line over the `AXI_FULL_BURST_VALID`/`AXI_FULL_BURST_READY` handshake. Drains packed pixel words from a first-word-fall-through FIFO and issues them as AXI4 INCR write bursts into a frame buffer in DDR. The block maintains the DDR write pointer, which wraps per frame and is re-based by a frame-start pulse.

## Interface
- `AXI4_DATA_WIDTH`, 128, width of the AXI data bus and FIFO word.
- `AXI4_ADDR_WIDTH`, 32, width of the AXI address bus.
- `BURST_LEN`, 16, beats per AXI burst (1..256).
- `LINE_BEATS`, 480, FIFO words per video line; must be a multiple of `BURST_LEN`.
- `FRAME_BASE_ADDR`, 32'h0000_0000, byte address of the first line of the frame.
- `FRAME_LINES`, 1080, lines per frame before the pointer wraps to base.
- `M_AXI_ACLK`  in  1  the block's single clock.
- `M_AXI_ARESETN`  in  1  reset, asynchronous and active-low.
- `frame_start`  in  1  one-cycle pulse, already synchronous to `M_AXI_ACLK`; re-bases the write pointer.
- `AXI_FULL_BURST_VALID`  in  1  line-write request from the packer.
- `AXI_FULL_BURST_READY`  out  1  request accepted when both VALID and READY are high.
- `fifo_rd_data`  in  `AXI4_DATA_WIDTH`  FWFT FIFO head word.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  pops the FIFO head.
- `M_AXI_AWADDR`  out  `AXI4_ADDR_WIDTH`  burst start byte address.
- `M_AXI_AWLEN`  out  8  constant `BURST_LEN-1`.
- `M_AXI_AWSIZE`  out  3  constant log2(`AXI4_DATA_WIDTH/8`).
- `M_AXI_AWBURST`  out  2  constant 2'b01 (INCR).
- `M_AXI_AWVALID` out, `M_AXI_AWREADY` in: 1 bit each, address handshake.
- `M_AXI_WDATA`  out  `AXI4_DATA_WIDTH`  equals `fifo_rd_data`.
- `M_AXI_WSTRB`  out  `AXI4_DATA_WIDTH/8`  all ones.
- `M_AXI_WLAST` out, `M_AXI_WVALID` out, `M_AXI_WREADY` in: 1 bit each, write-data handshake.
- `M_AXI_BRESP` in (2 bits), `M_AXI_BVALID` in (1 bit), `M_AXI_BREADY` out (1 bit): write-response channel.
- `wr_error`  out  1  sticky; set on any BRESP other than 2'b00.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- **IDLE.** `AXI_FULL_BURST_READY`=1. On VALID&READY: clear the burst counter and go to ADDR.
- **ADDR.** `M_AXI_AWVALID`=1, `M_AXI_AWADDR`=line pointer + burst_cnt×`BURST_LEN`×(`AXI4_DATA_WIDTH`/8). On AWREADY: clear the beat counter and go to DATA.
- **DATA.** `M_AXI_WVALID` = !`fifo_empty`, combinational. `fifo_rd_en` = WVALID & WREADY.
  - Beat counter increments on each accepted beat.
  - `M_AXI_WLAST`=1 when beat_cnt = `BURST_LEN`-1.
  - On the accepted last beat, go to RESP.
- **RESP.** `M_AXI_BREADY`=1. On BVALID:
  - If BRESP≠0, set `wr_error`.
  - If burst_cnt = `LINE_BEATS/BURST_LEN`-1, advance the line pointer and go to IDLE.
  - Otherwise increment burst_cnt and go to ADDR.
- **Line pointer advance.** Pointer += `LINE_BEATS`×bytes-per-beat and line_cnt += 1. When line_cnt reaches `FRAME_LINES`, the pointer becomes `FRAME_BASE_ADDR` and line_cnt becomes 0.
- **frame_start handling.**
  - In IDLE: the pointer becomes `FRAME_BASE_ADDR` and line_cnt becomes 0 on the next cycle.
  - In any other state: the pulse is latched into a pending flag. The re-base is applied instead of the normal advance when the line completes. The current line is never aborted.
- **Same-cycle frame_start and request acceptance in IDLE.** The re-base wins; the accepted line is written at `FRAME_BASE_ADDR`.
- **Ordering.** Only one AW is outstanding. The next AW is never issued before the previous B is received.
- **Address arithmetic.** Modulo 2^`AXI4_ADDR_WIDTH`. No 4 KB boundary check; the integrator aligns `FRAME_BASE_ADDR` and sizes bursts accordingly.

## Timing
- **Reset values.** State=IDLE. `AXI_FULL_BURST_READY`=1. AWVALID=0, WVALID=0, WLAST=0, BREADY=0, `fifo_rd_en`=0, `wr_error`=0. AWADDR=`FRAME_BASE_ADDR`. All counters=0.
- **Request to AWVALID.** `M_AXI_AWVALID` rises 1 cycle after the request handshake.
- **AWADDR stability.** `M_AXI_AWADDR` is registered and stable while AWVALID is high.
- **Address to data.** First WVALID can assert the cycle after the AW handshake.
- **Throughput.** Zero-bubble beats while the FIFO is non-empty and WREADY is high.
- **WDATA stability.** WVALID is not retracted while WREADY is low; the FIFO is not popped, so WDATA holds.
- **Burst-to-burst gap.** Minimum 1 cycle in RESP plus 1 cycle to the next AWVALID.
- **Reset mid-operation.** All outputs return to reset values immediately (asynchronous). Any partial AXI transaction is abandoned.

## Test plan
- **Single line, ideal slave.** FIFO pre-filled with 480 words, slave always ready, request pulse → 30 bursts at addresses 0x0, 0x100, …, 0x1D00, each with AWLEN=15 and WLAST on beat 16; 480 pops; READY returns high.
- **Backpressure.** Random WREADY/AWREADY at 50% → WDATA/WLAST held stable during stalls; data order matches FIFO order exactly; no extra pops.
- **FIFO underrun.** `fifo_empty`=1 for 20 cycles mid-burst → WVALID=0 and `fifo_rd_en`=0 throughout; the burst resumes with correct beat count.
- **Frame wrap.** `FRAME_LINES`=2, three requests → line addresses 0x0, 0x1E00, then 0x0.
- **Mid-line frame_start.** frame_start pulse during burst 5 of line 1 → line 1 completes at its own address; line 2 starts at `FRAME_BASE_ADDR`.
- **Error response.** BRESP=2'b10 on one burst → `wr_error`=1 and stays high; the line still completes all 30 bursts.

Source files
------------

// File: rtl/axi_full_burst_writer.sv
// axi_full_burst_writer: drains a FWFT FIFO into a DDR frame buffer as AXI4 INCR write bursts, one video line per request
module axi_full_burst_writer #(
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int BURST_LEN = 16,
  parameter int LINE_BEATS = 480,
  parameter logic [AXI4_ADDR_WIDTH-1:0] FRAME_BASE_ADDR = '0,
  parameter int FRAME_LINES = 1080
) (
  input  logic                         M_AXI_ACLK,
  input  logic                         M_AXI_ARESETN,
  input  logic                         frame_start,
  input  logic                         AXI_FULL_BURST_VALID,
  output logic                         AXI_FULL_BURST_READY,
  input  logic [AXI4_DATA_WIDTH-1:0]   fifo_rd_data,
  input  logic                         fifo_empty,
  output logic                         fifo_rd_en,
  output logic [AXI4_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                   M_AXI_AWLEN,
  output logic [2:0]                   M_AXI_AWSIZE,
  output logic [1:0]                   M_AXI_AWBURST,
  output logic                         M_AXI_AWVALID,
  input  logic                         M_AXI_AWREADY,
  output logic [AXI4_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [AXI4_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                         M_AXI_WLAST,
  output logic                         M_AXI_WVALID,
  input  logic                         M_AXI_WREADY,
  input  logic [1:0]                   M_AXI_BRESP,
  input  logic                         M_AXI_BVALID,
  output logic                         M_AXI_BREADY,
  output logic                         wr_error
);
  localparam int BYTES = AXI4_DATA_WIDTH/8;
  localparam int BURSTS = LINE_BEATS/BURST_LEN;
  localparam int BCW = $clog2(BURSTS+1);
  localparam int LCW = $clog2(FRAME_LINES+1);
  localparam logic [AXI4_ADDR_WIDTH-1:0] BURST_BYTES = AXI4_ADDR_WIDTH'(BURST_LEN*BYTES);
  localparam logic [AXI4_ADDR_WIDTH-1:0] LINE_BYTES = AXI4_ADDR_WIDTH'(LINE_BEATS*BYTES);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t state, state_nxt;
  logic [BCW-1:0] burst_cnt;
  logic [7:0] beat_cnt;
  logic [LCW-1:0] line_cnt;
  logic [AXI4_ADDR_WIDTH-1:0] line_ptr, aw_addr;
  logic pending, err, req, aw_hs, w_hs, b_hs, last_burst, rebase;
  assign AXI_FULL_BURST_READY = state == IDLE;
  assign M_AXI_AWVALID = state == ADDR;
  assign M_AXI_WVALID = state == DATA && !fifo_empty;
  assign M_AXI_WLAST = state == DATA && beat_cnt == 8'(BURST_LEN-1);
  assign M_AXI_BREADY = state == RESP;
  assign fifo_rd_en = w_hs;
  assign M_AXI_AWADDR = aw_addr;
  assign M_AXI_AWLEN = 8'(BURST_LEN-1);
  assign M_AXI_AWSIZE = 3'($clog2(BYTES));
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_WDATA = fifo_rd_data;
  assign M_AXI_WSTRB = '1;
  assign wr_error = err;
  assign req = AXI_FULL_BURST_VALID && AXI_FULL_BURST_READY;
  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs = M_AXI_BREADY && M_AXI_BVALID;
  assign last_burst = burst_cnt == BCW'(BURSTS-1);
  assign rebase = pending || frame_start;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = req ? ADDR : IDLE;
      ADDR: state_nxt = M_AXI_AWREADY ? DATA : ADDR;
      DATA: state_nxt = (w_hs && M_AXI_WLAST) ? RESP : DATA;
      RESP: state_nxt = b_hs ? (last_burst ? IDLE : ADDR) : RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
    if (!M_AXI_ARESETN) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN)
    if (!M_AXI_ARESETN) begin
      burst_cnt <= '0;
      beat_cnt <= '0;
      line_cnt <= '0;
      line_ptr <= FRAME_BASE_ADDR;
      aw_addr <= FRAME_BASE_ADDR;
      pending <= 1'b0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && frame_start) begin
        line_ptr <= FRAME_BASE_ADDR;
        line_cnt <= '0;
      end
      if (state != IDLE && frame_start) pending <= 1'b1;
      if (req) begin
        burst_cnt <= '0;
        aw_addr <= frame_start ? FRAME_BASE_ADDR : line_ptr;
      end
      if (aw_hs) beat_cnt <= '0;
      if (w_hs) beat_cnt <= beat_cnt + 8'd1;
      if (b_hs) begin
        if (M_AXI_BRESP != 2'b00) err <= 1'b1;
        if (last_burst) begin
          pending <= 1'b0;
          if (rebase || line_cnt == LCW'(FRAME_LINES-1)) begin
            line_ptr <= FRAME_BASE_ADDR;
            line_cnt <= '0;
          end else begin
            line_ptr <= line_ptr + LINE_BYTES;
            line_cnt <= line_cnt + LCW'(1);
          end
        end else begin
          burst_cnt <= burst_cnt + BCW'(1);
          aw_addr <= aw_addr + BURST_BYTES;
        end
      end
    end
endmodule

// File: tb/tb_axi_full_burst_writer.sv
// tb_axi_full_burst_writer: table-driven line tests with a randomized AXI slave, FIFO model and line-address reference model
module tb_axi_full_burst_writer;
  localparam int DW = 128;
  localparam int BL = 16;
  localparam int LB = 480;
  localparam int FL = 2;
  localparam int NB = LB/BL;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] BB = BL*16;
  localparam logic [31:0] LBY = LB*16;
  typedef struct {
    int fs;
    int pct;
    int err_burst;
    bit fs_mid;
    bit stall;
    logic [31:0] exp_addr;
    bit exp_err;
  } vec_t;
  logic clk = 0, rst_n = 0, frame_start = 0, req_valid = 0, req_ready;
  logic [DW-1:0] fifo_rd_data, wdata;
  logic fifo_empty, fifo_rd_en;
  logic [31:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst, bresp = 0;
  logic awvalid, awready = 0, wlast, wvalid, wready = 0, bvalid = 0, bready, wr_error;
  logic [15:0] wstrb;
  logic [DW-1:0] mem [0:8191];
  int head = 0, tail = 0, exp_idx = 0;
  bit stall = 0;
  int checks = 0, failures = 0;
  int pct = 100, err_burst = 99, aw_cnt = 0, w_cnt = 0, b_cnt = 0, beat = 0, ref_line = 0;
  bit aw_out = 0, resp_pend = 0, pop_due = 0, ref_pending = 0;
  bit p_wst = 0, p_ast = 0;
  logic [DW-1:0] p_wdata;
  logic p_wlast;
  logic [31:0] p_awaddr, first_addr = 0;
  vec_t tbl [8];
  assign fifo_rd_data = mem[head[12:0]];
  assign fifo_empty = stall || head == tail;
  axi_full_burst_writer #(.FRAME_LINES(FL)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .frame_start(frame_start),
    .AXI_FULL_BURST_VALID(req_valid), .AXI_FULL_BURST_READY(req_ready),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .wr_error(wr_error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask
  function automatic bit coin(input int p);
    return p >= 100 || int'($urandom_range(99)) < p;
  endfunction
  always begin
    @(negedge clk);
    if (pop_due) head++;
    pop_due = 0;
    awready = coin(pct);
    wready = coin(pct);
    bvalid = resp_pend && coin(pct);
    bresp = (aw_cnt - 1 == err_burst) ? 2'b10 : 2'b00;
    #1;
    if (rst_n) begin
      chk("rd_en_vs_handshake", fifo_rd_en, wvalid & wready);
      if (fifo_empty) chk("wvalid_on_empty", wvalid, 0);
      if (p_wst) begin
        chk("wvalid_hold", wvalid, 1);
        chk("wdata_hold", wdata, p_wdata);
        chk("wlast_hold", wlast, p_wlast);
      end
      if (p_ast) begin
        chk("awvalid_hold", awvalid, 1);
        chk("awaddr_hold", awaddr, p_awaddr);
      end
      if (awvalid) chk("aw_while_outstanding", aw_out | resp_pend, 0);
      if (awvalid && awready) begin
        if (aw_cnt == 0) first_addr = awaddr;
        chk("awaddr_model", awaddr, BASE + ref_line * LBY + aw_cnt * BB);
        chk("awlen", awlen, BL - 1);
        chk("awsize", awsize, 4);
        chk("awburst", awburst, 1);
        aw_cnt++;
        aw_out = 1;
      end
      if (wvalid && wready) begin
        chk("w_without_aw", aw_out, 1);
        chk("wdata_order", wdata, mem[exp_idx[12:0]]);
        chk("wlast", wlast, beat == BL - 1);
        chk("wstrb", wstrb, 16'hffff);
        exp_idx++;
        w_cnt++;
        pop_due = 1;
        if (beat == BL - 1) begin
          beat = 0;
          aw_out = 0;
          resp_pend = 1;
        end else beat++;
      end
      if (bvalid && bready) begin
        b_cnt++;
        resp_pend = 0;
      end
      p_wst = wvalid & !wready;
      p_wdata = wdata;
      p_wlast = wlast;
      p_ast = awvalid & !awready;
      p_awaddr = awaddr;
    end
  end
  task automatic fill();
    for (int i = 0; i < LB; i++) begin
      mem[tail[12:0]] = {$urandom, $urandom, $urandom, $urandom};
      tail++;
    end
  endtask
  task automatic chk_reset();
    chk("rst_ready", req_ready, 1);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_wr_error", wr_error, 0);
    chk("rst_awaddr", awaddr, BASE);
  endtask
  task automatic run_line(input vec_t v);
    int pops0, cyc, stall_left;
    bit fs_done, st_done, want_fs;
    fs_done = 0;
    st_done = 0;
    want_fs = 0;
    stall_left = 0;
    cyc = 0;
    fill();
    @(negedge clk);
    pct = v.pct;
    err_burst = v.err_burst;
    aw_cnt = 0;
    w_cnt = 0;
    b_cnt = 0;
    beat = 0;
    pops0 = head;
    exp_idx = head;
    if (v.fs == 1) begin
      frame_start = 1;
      ref_line = 0;
      ref_pending = 0;
      @(negedge clk);
      frame_start = 0;
    end
    if (v.fs == 2) begin
      frame_start = 1;
      ref_line = 0;
      ref_pending = 0;
    end
    req_valid = 1;
    #1 chk("req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 0;
    frame_start = 0;
    #1;
    chk("awvalid_after_req", awvalid, 1);
    chk("awaddr_line", awaddr, v.exp_addr);
    while (!(b_cnt == NB && req_ready) && cyc < 20000) begin
      @(negedge clk);
      frame_start = want_fs;
      want_fs = 0;
      stall = stall_left > 0;
      if (stall_left > 0) stall_left--;
      #2;
      if (stall) begin
        chk("underrun_wvalid", wvalid, 0);
        chk("underrun_rd_en", fifo_rd_en, 0);
      end
      if (v.fs_mid && aw_cnt == 5 && !fs_done) begin
        want_fs = 1;
        fs_done = 1;
        ref_pending = 1;
      end
      if (v.stall && w_cnt >= 3 * BL + 5 && !st_done) begin
        stall_left = 20;
        st_done = 1;
      end
      cyc++;
    end
    frame_start = 0;
    stall = 0;
    chk("line_timeout", cyc < 20000, 1);
    chk("line_bursts", aw_cnt, NB);
    chk("line_resps", b_cnt, NB);
    chk("line_beats", w_cnt, LB);
    chk("line_pops", head - pops0, LB);
    chk("line_first_addr", first_addr, v.exp_addr);
    chk("wr_error", wr_error, v.exp_err);
    chk("ready_after_line", req_ready, 1);
    ref_line = ref_pending ? 0 : (ref_line + 1) % FL;
    ref_pending = 0;
  endtask
  initial begin
    int cyc;
    tbl[0] = '{0, 100, 99, 0, 0, 32'h0000, 0};
    tbl[1] = '{0, 100, 99, 0, 0, 32'h1E00, 0};
    tbl[2] = '{0, 100, 99, 0, 0, 32'h0000, 0};
    tbl[3] = '{0, 50, 99, 1, 0, 32'h1E00, 0};
    tbl[4] = '{0, 100, 99, 0, 1, 32'h0000, 0};
    tbl[5] = '{1, 70, 99, 0, 0, 32'h0000, 0};
    tbl[6] = '{2, 50, 7, 0, 0, 32'h0000, 1};
    tbl[7] = '{0, 100, 99, 0, 0, 32'h1E00, 1};
    repeat (3) @(negedge clk);
    #1 chk_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) run_line(tbl[i]);
    fill();
    @(negedge clk);
    pct = 50;
    aw_cnt = 0;
    w_cnt = 0;
    b_cnt = 0;
    beat = 0;
    exp_idx = head;
    req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    cyc = 0;
    while (w_cnt < 40 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("midop_progress", w_cnt >= 40, 1);
    @(negedge clk);
    rst_n = 0;
    #1 chk_reset();
    #1;
    head = tail;
    pop_due = 0;
    resp_pend = 0;
    aw_out = 0;
    beat = 0;
    p_wst = 0;
    p_ast = 0;
    ref_line = 0;
    ref_pending = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    run_line('{0, 100, 99, 0, 0, 32'h0000, 0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
